control_ram_write_arbiter: RTL
==============================

Name: control_ram_write_arbiter

Overview:
- Shares the single framebuffer RAM write port between NUM_REQUESTERS command sub-modules (readpixel, readrow, fill, …).
- Each requester holds a level request, is granted exclusive ownership round-robin, and releases on its done pulse.
- Sits between the control_cmd_* write outputs and the framebuffer write port. Registers the muxed write path.

Parameters:
- NUM_REQUESTERS, 4, number of requester slots; legal range 2..8.
- BYTES_PER_PIXEL, params_pkg::BYTES_PER_PIXEL, sizes the pixel-select field.
- PIXEL_HEIGHT, params_pkg::PIXEL_HEIGHT, sizes the row address.
- PIXEL_WIDTH, params_pkg::PIXEL_WIDTH, sizes the column address.
- TIMEOUT_CYCLES, 1024, ownership watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQUESTERS  level request per requester; held until granted.
- req_done  in  NUM_REQUESTERS  1-cycle release pulse from the owner.
- req_we  in  NUM_REQUESTERS  per-requester write strobe.
- req_row  in  NUM_REQUESTERS*RW  packed row addresses; RW = calc_pkg::num_row_address_bits(PIXEL_HEIGHT).
- req_col  in  NUM_REQUESTERS*CW  packed column addresses; CW = calc_pkg::num_column_address_bits(PIXEL_WIDTH).
- req_pixel  in  NUM_REQUESTERS*PW  packed pixel-select fields; PW = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL).
- req_data  in  NUM_REQUESTERS*8  packed write bytes.
- grant  out  NUM_REQUESTERS  one-hot ownership; all zero when idle.
- ram_we  out  1  registered write enable to the framebuffer.
- ram_row  out  RW  registered row address.
- ram_col  out  CW  registered column address.
- ram_pixel  out  PW  registered pixel-select field.
- ram_data  out  8  registered write byte.
- busy  out  1  high while in OWNED.
- err_drop  out  1  sticky: a non-owner asserted req_we.

Behaviour:
- Reset values (asynchronous): grant, ram_*, busy and err_drop all 0; rr_ptr = 0; state IDLE.
- State IDLE:
  - If any req bit is set, select the first set index scanning from rr_ptr upward, mod NUM_REQUESTERS.
  - Next cycle: grant is one-hot for that index, busy = 1, state OWNED.
  - With no requests, stay in IDLE.
- State OWNED:
  - Each cycle, register the owner's req_we/row/col/pixel/data onto ram_*. Latency is 1 cycle from owner input to ram_*.
  - ram_we is 0 whenever the owner's req_we is 0; address and data outputs then hold their last values.
- Release: the owner's req_done = 1, or the owner's req deasserting, ends ownership.
  - Next cycle: grant = 0, busy = 0, rr_ptr = (owner+1) mod NUM_REQUESTERS, state IDLE.
  - A write strobed in the same cycle as req_done is still forwarded.
- Guaranteed gap: at least one IDLE cycle between consecutive grants. No back-to-back grant handoff.
- req_done from a non-owner is ignored.
- req_we from any non-owner: the write is dropped (never reaches ram_*) and err_drop sets. err_drop clears only on reset.
- rr_ptr wrap-around: index NUM_REQUESTERS-1 wraps to 0.
- Reset mid-ownership: immediate return to reset values; the in-flight write is lost.
- Packed slicing: requester i occupies bits [i*W +: W] of each packed bus.

Optional Feature:
- Macro: CONTROL_RAM_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs while OWNED and clears on entry to OWNED.
  - When it reaches TIMEOUT_CYCLES-1 without a release, force a release exactly as if req_done had arrived, and pulse an extra output timeout_pulse (1 cycle).
- Without the macro: no counter and no timeout_pulse port. An owner may hold the port indefinitely.

Decomposition:
- params_pkg holds the defaults.
- calc_pkg supplies the RW/CW/PW width functions.
- Add to calc_pkg: a function num_requester_index_bits(NUM_REQUESTERS) for rr_ptr/owner width.
- Add to a shared package: a typedef enum {IDLE, OWNED} for the state.
- One sub-module: rr_priority_pick. It is combinational and takes the request vector plus rr_ptr, returning the one-hot pick and the binary index. It is reusable by future arbiters.

Test Plan:
- Single requester: req[1]=1 → grant=4'b0010 one cycle later. Owner writes row 3, col 5, data 8'hA5 → ram_we=1 with those values the next cycle. req_done[1] → grant=0, rr_ptr=2.
- Contention: req=4'b1111 from reset → grant sequence 0,1,2,3,0, each release by req_done. Each grant is separated by exactly one idle cycle.
- Wrap: rr_ptr=3 with req=4'b1001 → requester 3 is granted before 0. After release rr_ptr=0 and requester 0 is granted.
- Intruder write: requester 0 owns; requester 2 pulses req_we with data 8'h5A → ram_data never shows 8'h5A and err_drop=1, sticky until reset.
- Reset mid-write: assert reset while OWNED and ram_we=1 → all outputs are 0 immediately. After release, req=4'b0100 is granted in IDLE order starting from rr_ptr=0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): owner never sends done → grant drops after 16 OWNED cycles and timeout_pulse is high for 1 cycle.

Source files
------------

// File: rtl/calc_pkg.sv
// Address and field width helpers derived from framebuffer geometry.
package calc_pkg;
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned num_row_address_bits(input int unsigned pixel_height);
    return clog2_min1(pixel_height);
  endfunction

  function automatic int unsigned num_column_address_bits(input int unsigned pixel_width);
    return clog2_min1(pixel_width);
  endfunction

  function automatic int unsigned num_pixelcolorselect_bits(input int unsigned bytes_per_pixel);
    return clog2_min1(bytes_per_pixel);
  endfunction

  function automatic int unsigned num_requester_index_bits(input int unsigned num_requesters);
    return clog2_min1(num_requesters);
  endfunction
endpackage

// File: rtl/control_ram_write_arbiter_pkg.sv
// Shared types for the framebuffer write-port arbiter.
package control_ram_write_arbiter_pkg;
  typedef enum logic [0:0] {StIdle, StOwned} arb_state_e;
endpackage

// File: rtl/params_pkg.sv
// Default framebuffer geometry shared by the control command blocks.
package params_pkg;
  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned PIXEL_HEIGHT    = 64;
  localparam int unsigned PIXEL_WIDTH     = 64;
endpackage

// File: rtl/control_ram_write_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at N.
module rr_priority_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        idx        = cand;
      end
    end
  end
endmodule

// File: rtl/control_ram_write_arbiter.sv
// Round-robin owner arbitration of the framebuffer write port with a registered write path.
// Optional ownership watchdog: define CONTROL_RAM_ARBITER_TIMEOUT_EN.
module control_ram_write_arbiter
  import control_ram_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS  = 4,
  parameter int unsigned BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
  parameter int unsigned PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT,
  parameter int unsigned PIXEL_WIDTH     = params_pkg::PIXEL_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned RW = calc_pkg::num_row_address_bits(PIXEL_HEIGHT),
  localparam int unsigned CW = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
  localparam int unsigned PW = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL),
  localparam int unsigned IW = calc_pkg::num_requester_index_bits(NUM_REQUESTERS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQUESTERS-1:0]    req,
  input  logic [NUM_REQUESTERS-1:0]    req_done,
  input  logic [NUM_REQUESTERS-1:0]    req_we,
  input  logic [NUM_REQUESTERS*RW-1:0] req_row,
  input  logic [NUM_REQUESTERS*CW-1:0] req_col,
  input  logic [NUM_REQUESTERS*PW-1:0] req_pixel,
  input  logic [NUM_REQUESTERS*8-1:0]  req_data,
  output logic [NUM_REQUESTERS-1:0]    grant,
  output logic                         ram_we,
  output logic [RW-1:0]                ram_row,
  output logic [CW-1:0]                ram_col,
  output logic [PW-1:0]                ram_pixel,
  output logic [7:0]                   ram_data,
  output logic                         busy,
  output logic                         err_drop
`ifdef CONTROL_RAM_ARBITER_TIMEOUT_EN
  ,
  output logic                         timeout_pulse
`endif
);

  if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8 || TIMEOUT_CYCLES < 2) begin : gen_param_check
    $error("control_ram_write_arbiter: illegal parameter value");
  end

  arb_state_e                state_q, state_d;
  logic [IW-1:0]             owner_q, owner_d;
  logic [IW-1:0]             ptr_q, ptr_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [NUM_REQUESTERS-1:0] pick;
  logic [IW-1:0]             pick_idx;
  logic                      owned;
  logic                      user_release;
  logic                      timeout_hit;

  logic          ram_we_q;
  logic [RW-1:0] ram_row_q;
  logic [CW-1:0] ram_col_q;
  logic [PW-1:0] ram_pixel_q;
  logic [7:0]    ram_data_q;
  logic          err_drop_q;

  rr_priority_pick #(
    .N  (NUM_REQUESTERS),
    .IW (IW)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign owned        = (state_q == StOwned);
  assign user_release = req_done[owner_q] | ~req[owner_q];

`ifdef CONTROL_RAM_ARBITER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  assign timeout_hit = owned && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  // Count only while ownership continues; any entry into OWNED starts from zero.
  assign cnt_d = (owned && state_d == StOwned) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_hit && !user_release;
    end
  end

  assign timeout_pulse = timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StOwned;
          owner_d = pick_idx;
          grant_d = pick;
        end
      end
      StOwned: begin
        if (user_release || timeout_hit) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = (owner_q == IW'(NUM_REQUESTERS - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = owned;
    grant     = grant_q;
    ram_we    = ram_we_q;
    ram_row   = ram_row_q;
    ram_col   = ram_col_q;
    ram_pixel = ram_pixel_q;
    ram_data  = ram_data_q;
    err_drop  = err_drop_q;
  end

  // Registered write path; only the owner's strobe reaches the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we_q    <= 1'b0;
      ram_row_q   <= '0;
      ram_col_q   <= '0;
      ram_pixel_q <= '0;
      ram_data_q  <= '0;
      err_drop_q  <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      if (owned && req_we[owner_q]) begin
        ram_we_q    <= 1'b1;
        ram_row_q   <= req_row[int'(owner_q) * RW +: RW];
        ram_col_q   <= req_col[int'(owner_q) * CW +: CW];
        ram_pixel_q <= req_pixel[int'(owner_q) * PW +: PW];
        ram_data_q  <= req_data[int'(owner_q) * 8 +: 8];
      end
      if (|(req_we & ~grant_q)) begin
        err_drop_q <= 1'b1;
      end
    end
  end

endmodule
